// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO feeding an external ALU, with a registered
// valid/ready result stage carrying the opcode and a zero flag.
module alu_cmd_issue #(
    parameter int ALU_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ALU_WIDTH-1:0]         in_a,
    input  logic [ALU_WIDTH-1:0]         in_b,
    input  logic [1:0]                   in_opcode,
    output logic [ALU_WIDTH-1:0]         alu_a,
    output logic [ALU_WIDTH-1:0]         alu_b,
    output logic [1:0]                   alu_opcode,
    input  logic [ALU_WIDTH-1:0]         alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ALU_WIDTH-1:0]         out_result,
    output logic [1:0]                   out_opcode,
    output logic                         out_zero,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 2*ALU_WIDTH + 2;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, empty;
    logic [EW-1:0] head;

    assign empty    = (count == '0);
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = !empty & (!out_valid | out_ready);
    assign head     = empty ? '0 : mem[rd_ptr];
    assign {alu_opcode, alu_a, alu_b} = head;

    always_ff @(posedge clk)
        if (push && !rst && !flush)
            mem[wr_ptr] <= {in_opcode, in_a, in_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_zero   <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            // a pop while out_ready is low only happens when the stage is empty
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_result <= alu_result;
                out_opcode <= alu_opcode;
                out_zero   <= (alu_result == '0);
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
